// File: rtl/instr_mem_responder_if.sv
// Fetch and load-port signal bundle between the core-side driver and the
// instruction-memory responder.
`timescale 1ns/1ps
interface instr_mem_responder_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  iMemRead;
  logic [31:0]           pc;
  logic [31:0]           instruction;
  logic                  iMemValid;
  logic                  iMemBusy;
  logic                  iMemFault;
  logic                  loadEn;
  logic [DEPTH_LOG2-1:0] loadAddr;
  logic [31:0]           loadData;

  // Core / loader side: issues fetches and fills the array
  modport master (
    output iMemRead, pc, loadEn, loadAddr, loadData,
    input  instruction, iMemValid, iMemBusy, iMemFault
  );

  // Memory side: accepts fetches and returns instruction words
  modport slave (
    input  iMemRead, pc, loadEn, loadAddr, loadData,
    output instruction, iMemValid, iMemBusy, iMemFault
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits a fixed
// number of cycles, then returns the addressed word (or a NOP on a misaligned
// or out-of-range fetch) with a one-cycle valid pulse. A load port writes the
// array in any state.
`timescale 1ns/1ps
module instr_mem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input logic                  clk,
  input logic                  rst,
  instr_mem_responder_if.slave bus
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam int          ADDR_HI  = DEPTH_LOG2 + 2;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH];

  logic        enterResp;
  logic [31:0] fetchAddr;
  logic        fetchFault;
  logic [DEPTH_LOG2-1:0] fetchIdx;

  // With zero wait states the response is launched on the accepting edge, so
  // the live pc is used there; otherwise the latched address is used.
  always_comb begin
    fetchAddr  = (state_q == ST_IDLE) ? bus.pc : addr_q;
    fetchIdx   = fetchAddr[ADDR_HI-1:2];
    fetchFault = (fetchAddr[1:0] != 2'b00) || (fetchAddr[31:ADDR_HI] != '0);
  end

  // Next-state, counter and response-register logic for the fetch FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    enterResp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.iMemRead && !bus.loadEn) begin
          addr_d = bus.pc;
          cnt_d  = WAIT_CNT;
          if (WAIT_CNT == 4'd0) begin
            state_d   = ST_RESP;
            enterResp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d   = ST_RESP;
          cnt_d     = 4'd0;
          enterResp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = enterResp;
    fault_d = enterResp && fetchFault;
    instr_d = instr_q;
    if (enterResp) begin
      instr_d = fetchFault ? NOP_WORD : mem[fetchIdx];
    end
  end

  // State, counter, latched address and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Load-port write; the read above samples the pre-write word on a shared edge
  always_ff @(posedge clk) begin
    if (bus.loadEn) begin
      mem[bus.loadAddr] <= bus.loadData;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.iMemValid   = valid_q;
  assign bus.iMemFault   = fault_q;
  assign bus.iMemBusy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: one instance with two wait states and one
// with none, sharing a load bus, checked against a word-array model.
`timescale 1ns/1ps
module tb_instr_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rstA;
  logic rstB;

  int checks   = 0;
  int failures = 0;

  logic [31:0] modelMem [DEPTH];

  instr_mem_responder_if #(.DEPTH_LOG2(10)) ifA ();
  instr_mem_responder_if #(.DEPTH_LOG2(10)) ifB ();

  instr_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2), .NOP_WORD(NOP)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (ifA)
  );

  instr_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .NOP_WORD(NOP)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (ifB)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word for a fetch address, straight from the address rules
  function automatic logic [31:0] refWord(input logic [31:0] p);
    if ((p % 4) != 0 || (p / 4) >= DEPTH) return NOP;
    return modelMem[p / 4];
  endfunction

  function automatic logic [31:0] refFault(input logic [31:0] p);
    return ((p % 4) != 0 || (p / 4) >= DEPTH) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] obsInstr(input bit b);
    return b ? ifB.instruction : ifA.instruction;
  endfunction
  function automatic logic [31:0] obsValid(input bit b);
    return {31'd0, (b ? ifB.iMemValid : ifA.iMemValid)};
  endfunction
  function automatic logic [31:0] obsBusy(input bit b);
    return {31'd0, (b ? ifB.iMemBusy : ifA.iMemBusy)};
  endfunction
  function automatic logic [31:0] obsFault(input bit b);
    return {31'd0, (b ? ifB.iMemFault : ifA.iMemFault)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic driveReq(input bit b, input logic rd, input logic [31:0] p);
    if (b) begin
      ifB.iMemRead = rd;
      ifB.pc       = p;
    end else begin
      ifA.iMemRead = rd;
      ifA.pc       = p;
    end
  endtask

  // Both instances share the same load traffic so one model serves both
  task automatic applyStimulus(input logic en, input logic [9:0] a, input logic [31:0] d);
    ifA.loadEn = en; ifA.loadAddr = a; ifA.loadData = d;
    ifB.loadEn = en; ifB.loadAddr = a; ifB.loadData = d;
  endtask

  // One complete fetch; optionally writes a word on the edge entering RESP
  task automatic doFetch(input bit b, input logic [31:0] p, input bit wrAtResp,
                         input logic [9:0] wrAddr, input logic [31:0] wrData);
    int ws;
    logic [31:0] expW;
    logic [31:0] expF;
    ws   = b ? 0 : 2;
    expW = refWord(p);
    expF = refFault(p);
    driveReq(b, 1'b1, p);
    tick();
    for (int k = 1; k <= ws + 1; k++) begin
      checkOutput(b ? "B.busy" : "A.busy", obsBusy(b), 32'd1);
      checkOutput(b ? "B.valid" : "A.valid", obsValid(b), (k == ws + 1) ? 32'd1 : 32'd0);
      if (k == ws + 1) begin
        checkOutput(b ? "B.instr" : "A.instr", obsInstr(b), expW);
        checkOutput(b ? "B.fault" : "A.fault", obsFault(b), expF);
      end
      if (k == 1) driveReq(b, 1'b0, p);
      if (wrAtResp && k == ws) applyStimulus(1'b1, wrAddr, wrData);
      tick();
      if (wrAtResp && k == ws) begin
        applyStimulus(1'b0, '0, '0);
        modelMem[wrAddr] = wrData;
      end
    end
    checkOutput(b ? "B.idleBusy" : "A.idleBusy", obsBusy(b), 32'd0);
    checkOutput(b ? "B.idleValid" : "A.idleValid", obsValid(b), 32'd0);
    checkOutput(b ? "B.idleFault" : "A.idleFault", obsFault(b), 32'd0);
  endtask

  // Directed and randomized sequence
  initial begin
    int          vcyc [3];
    logic [31:0] vword [3];
    int          nv;
    int          busyCount;
    logic [31:0] p;
    logic [31:0] d;

    rstA = 1'b1; rstB = 1'b1;
    driveReq(1'b0, 1'b0, 32'd0);
    driveReq(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, '0, '0);

    #1 rstA = 1'b0; rstB = 1'b0;
    #2;
    checkOutput("rst.A.instr", ifA.instruction, 32'd0);
    checkOutput("rst.A.valid", obsValid(1'b0), 32'd0);
    checkOutput("rst.A.busy",  obsBusy(1'b0),  32'd0);
    checkOutput("rst.A.fault", obsFault(1'b0), 32'd0);
    checkOutput("rst.B.instr", ifB.instruction, 32'd0);
    checkOutput("rst.B.busy",  obsBusy(1'b1),  32'd0);
    tick(); tick();
    rstA = 1'b1; rstB = 1'b1;
    tick();

    // Fill the whole array with random words, known word at index 4
    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 4) ? 32'h00A0_0093 : $urandom;
      applyStimulus(1'b1, 10'(i), d);
      modelMem[i] = d;
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    tick();

    $display("[TB] basic and faulting fetches");
    doFetch(1'b0, 32'h10, 1'b0, '0, '0);
    doFetch(1'b0, 32'h12, 1'b0, '0, '0);
    doFetch(1'b0, 32'h1000, 1'b0, '0, '0);
    doFetch(1'b0, 32'hFFFF_FFFC, 1'b0, '0, '0);
    doFetch(1'b1, 32'h8, 1'b0, '0, '0);
    doFetch(1'b1, 32'h7, 1'b0, '0, '0);

    $display("[TB] randomized fetches");
    for (int i = 0; i < 16; i++) begin
      p = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2);
      doFetch(i[0], p, 1'b0, '0, '0);
    end

    $display("[TB] request held high across two fetches");
    nv = 0; busyCount = 0;
    vcyc = '{-1, -1, -1};
    vword = '{32'd0, 32'd0, 32'd0};
    driveReq(1'b0, 1'b1, 32'h0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      busyCount += ifA.iMemBusy ? 1 : 0;
      if (ifA.iMemValid && nv < 3) begin
        vcyc[nv]  = cyc;
        vword[nv] = ifA.instruction;
        nv++;
      end
      if (cyc == 1) driveReq(1'b0, 1'b1, 32'h4);
      if (cyc == 7) driveReq(1'b0, 1'b0, 32'h4);
    end
    checkOutput("hold.count",  32'(nv), 32'd2);
    checkOutput("hold.cyc0",   32'(vcyc[0]), 32'd3);
    checkOutput("hold.cyc1",   32'(vcyc[1]), 32'd7);
    checkOutput("hold.word0",  vword[0], modelMem[0]);
    checkOutput("hold.word1",  vword[1], modelMem[1]);
    checkOutput("hold.busy",   32'(busyCount), 32'd6);
    tick();

    $display("[TB] load/fetch conflict in IDLE");
    d = $urandom;
    driveReq(1'b0, 1'b1, 32'h14);
    applyStimulus(1'b1, 10'd5, d);
    tick();
    checkOutput("conf.noAccept", obsBusy(1'b0), 32'd0);
    applyStimulus(1'b0, '0, '0);
    modelMem[5] = d;
    tick();
    checkOutput("conf.accept", obsBusy(1'b0), 32'd1);
    checkOutput("conf.valid0", obsValid(1'b0), 32'd0);
    driveReq(1'b0, 1'b0, 32'h14);
    tick();
    checkOutput("conf.valid1", obsValid(1'b0), 32'd0);
    tick();
    checkOutput("conf.valid2", obsValid(1'b0), 32'd1);
    checkOutput("conf.word",   ifA.instruction, refWord(32'h14));
    tick();

    $display("[TB] write on the edge entering RESP");
    doFetch(1'b0, 32'h10, 1'b1, 10'd4, 32'hDEAD_BEEF);
    doFetch(1'b0, 32'h10, 1'b0, '0, '0);
    checkOutput("rf.newWord", ifA.instruction, 32'hDEAD_BEEF);

    $display("[TB] reset during WAIT");
    driveReq(1'b0, 1'b1, 32'h10);
    tick();
    checkOutput("mid.busy", obsBusy(1'b0), 32'd1);
    driveReq(1'b0, 1'b0, 32'h10);
    #2 rstA = 1'b0;
    #1;
    checkOutput("mid.rstBusy",  obsBusy(1'b0),  32'd0);
    checkOutput("mid.rstValid", obsValid(1'b0), 32'd0);
    checkOutput("mid.rstFault", obsFault(1'b0), 32'd0);
    checkOutput("mid.rstInstr", ifA.instruction, 32'd0);
    tick();
    rstA = 1'b1;
    nv = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      nv += ifA.iMemValid ? 1 : 0;
    end
    checkOutput("mid.noValid", 32'(nv), 32'd0);
    doFetch(1'b0, 32'h10, 1'b0, '0, '0);

    $display("[TB] zero-wait back-to-back fetches");
    nv = 0;
    vcyc = '{-1, -1, -1};
    vword = '{32'd0, 32'd0, 32'd0};
    driveReq(1'b1, 1'b1, 32'h8);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      if (ifB.iMemValid && nv < 3) begin
        vcyc[nv]  = cyc;
        vword[nv] = ifB.instruction;
        nv++;
      end
      if (cyc == 1) driveReq(1'b1, 1'b1, 32'hC);
      if (cyc == 3) driveReq(1'b1, 1'b1, 32'h10);
      if (cyc == 5) driveReq(1'b1, 1'b0, 32'h10);
    end
    checkOutput("b2b.count", 32'(nv), 32'd3);
    checkOutput("b2b.cyc0",  32'(vcyc[0]), 32'd1);
    checkOutput("b2b.cyc1",  32'(vcyc[1]), 32'd3);
    checkOutput("b2b.cyc2",  32'(vcyc[2]), 32'd5);
    checkOutput("b2b.word0", vword[0], refWord(32'h8));
    checkOutput("b2b.word1", vword[1], refWord(32'hC));
    checkOutput("b2b.word2", vword[2], refWord(32'h10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
